// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_fetch_stage_pkg : shared types and constants for the fetch stage     |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package if_fetch_stage_pkg;

  localparam int unsigned IfFifoDepth = 2;
  localparam logic [31:0] ResetVector = 32'h0000_0000;
  localparam logic [31:0] NopInstr    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } if_entry_t;

  typedef enum logic [0:0] {
    IF_RUN  = 1'b0,
    IF_HALT = 1'b1
  } if_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_fifo : in-order instruction buffer with synchronous clear            |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module if_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned Depth = IfFifoDepth,
  localparam int unsigned AW   = $clog2(Depth),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  if_entry_t     push_data,
  input  logic          pop,
  output if_entry_t     head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  if_entry_t       mem [Depth];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the top masks the head whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(Depth));

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_fetch_stage : fetch PC, imem req/gnt/rvalid, buffered output to decode|
// | Optional IF_PERF_CNT_EN adds pop and stall counters. Rev 1.0 - initial  |
// +------------------------------------------------------------------------+
module if_fetch_stage #(
  parameter logic [31:0] ResetVector = if_fetch_stage_pkg::ResetVector,
  parameter int unsigned FifoDepth   = if_fetch_stage_pkg::IfFifoDepth
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_err,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_access_fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  import if_fetch_stage_pkg::*;

  localparam int unsigned CW = $clog2(FifoDepth) + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  if_state_e   state;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic [31:0] redirect_pc;
  cnt_t        outstanding;
  cnt_t        drop;
  cnt_t        fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  if_entry_t   head;
  if_entry_t   push_entry;
  logic        credit_ok;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic        unused_redirect_lsb;

  assign redirect_pc         = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  // Buffered plus in-flight entries may never exceed the buffer size.
  assign credit_ok  = (sum_t'(fifo_count) + sum_t'(outstanding)) < sum_t'(FifoDepth);
  assign o_imem_req = fetch_en && (state == IF_RUN) && !i_redirect && credit_ok;
  assign req_fire   = o_imem_req && i_imem_gnt;
  assign push       = i_imem_rvalid && !i_redirect && (drop == '0);
  assign pop        = !fifo_empty && !i_stall;

  assign push_entry.instr = i_imem_err ? NopInstr : i_imem_rdata;
  assign push_entry.pc    = resp_pc;
  assign push_entry.fault = i_imem_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IF_RUN;
      fetch_en    <= 1'b0;
      fetch_pc    <= ResetVector;
      resp_pc     <= ResetVector;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      fetch_en <= 1'b1;
      if (i_redirect) begin
        // Everything still in flight, minus a response landing now, is stale.
        state       <= IF_RUN;
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        outstanding <= outstanding - cnt_t'(i_imem_rvalid);
        drop        <= outstanding - cnt_t'(i_imem_rvalid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     resp_pc  <= resp_pc + 32'd4;
        outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(i_imem_rvalid);
        if (i_imem_rvalid && (drop != '0)) drop <= drop - cnt_t'(1);
        if (push && i_imem_err) state <= IF_HALT;
      end
    end
  end

  if_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (i_redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

  assign o_imem_addr    = fetch_pc;
  assign o_valid        = !fifo_empty;
  assign o_instr        = o_valid ? head.instr : '0;
  assign o_pc           = o_valid ? head.pc    : '0;
  assign o_access_fault = o_valid && head.fault;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fetch_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (pop)                o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (o_valid && i_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_if_fetch_stage : randomized self-checking bench with reference model |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_if_fetch_stage;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_imem_err = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_stall = 1'b0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_access_fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] o_fetch_cnt;
  logic [31:0] o_stall_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(
    .ResetVector (RV),
    .FifoDepth   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_gnt     (i_imem_gnt),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .i_imem_err     (i_imem_err),
    .i_redirect     (i_redirect),
    .i_redirect_pc  (i_redirect_pc),
    .i_stall        (i_stall),
    .o_valid        (o_valid),
    .o_instr        (o_instr),
    .o_pc           (o_pc),
    .o_access_fault (o_access_fault)
`ifdef IF_PERF_CNT_EN
    ,
    .o_fetch_cnt    (o_fetch_cnt),
    .o_stall_cnt    (o_stall_cnt)
`endif
  );

  typedef struct {logic [31:0] addr; int epoch;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic fault;} exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          epoch = 0;
  int          since_reset = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] next_req_pc = RV;
  bit          halted = 0;
  bit          fault_en = 0;
  bit          rand_fault = 0;
  logic [31:0] fault_addr = '0;
  bit          hold_prev = 0;
  logic [31:0] hold_pc, hold_instr;
  logic        hold_fault;
  logic        s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [31:0] s_fcnt, s_scnt;
  logic [31:0] model_fetch = '0;
  logic [31:0] model_stall = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} + 32'h1234_5678;
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
    return (fault_en && a == fault_addr) || (rand_fault && a[6:2] == 5'd13);
  endfunction

  // One clock cycle: drive at posedge+1, check at posedge+4, update model after the edge.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic stall,
                      input int gnt_pct, input int rv_pct);
    logic        fire, pop, rv, err, exp_req;
    logic [31:0] addr;
    mreq_t       m;
    exp_t        e;
    i_redirect    = redir;
    i_redirect_pc = tgt;
    i_stall       = stall;
    i_imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    rv            = (mem_q.size() != 0) && ($urandom_range(0, 99) < rv_pct);
    i_imem_rvalid = rv;
    if (rv) begin
      i_imem_rdata = mem_word(mem_q[0].addr);
      i_imem_err   = is_fault(mem_q[0].addr);
    end else begin
      i_imem_rdata = $urandom;
      i_imem_err   = 1'($urandom_range(0, 1));
    end
    err = i_imem_err;
    #3;
    s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid;
    s_pc = o_pc; s_instr = o_instr; s_fault = o_access_fault;
    checks++;
    if (o_valid !== (exp_q.size() != 0)) begin
      fails++; $display("FAIL valid: got %b expected %b", o_valid, exp_q.size() != 0);
    end
    if (since_reset > 0) begin
      exp_req = !redir && !halted && (mem_q.size() + exp_q.size() < DEPTH);
      checks++;
      if (o_imem_req !== exp_req) begin
        fails++; $display("FAIL req: got %b expected %b", o_imem_req, exp_req);
      end
    end
    if (o_imem_req === 1'b1 && !redir) begin
      checks++;
      if (o_imem_addr !== next_req_pc) begin
        fails++; $display("FAIL req_addr: got %h expected %h", o_imem_addr, next_req_pc);
      end
    end
    if (hold_prev) begin
      checks++;
      if ({o_valid, o_pc, o_instr, o_access_fault} !== {1'b1, hold_pc, hold_instr, hold_fault}) begin
        fails++; $display("FAIL stall_hold: got pc %h instr %h expected pc %h instr %h",
                          o_pc, o_instr, hold_pc, hold_instr);
      end
    end
    if (o_valid === 1'b1 && exp_q.size() != 0) begin
      checks++;
      if ({o_pc, o_instr, o_access_fault} !== {exp_q[0].pc, exp_q[0].instr, exp_q[0].fault}) begin
        fails++; $display("FAIL entry: got pc %h instr %h fault %b expected pc %h instr %h fault %b",
                          o_pc, o_instr, o_access_fault, exp_q[0].pc, exp_q[0].instr, exp_q[0].fault);
      end
    end
    fire = o_imem_req && i_imem_gnt;
    pop  = o_valid && !stall;
    addr = o_imem_addr;
    hold_prev = o_valid && stall && !redir;
    hold_pc = o_pc; hold_instr = o_instr; hold_fault = o_access_fault;
`ifdef IF_PERF_CNT_EN
    s_fcnt = o_fetch_cnt; s_scnt = o_stall_cnt;
    checks++;
    if ({o_fetch_cnt, o_stall_cnt} !== {model_fetch, model_stall}) begin
      fails++; $display("FAIL perf_cnt: got %0d/%0d expected %0d/%0d",
                        o_fetch_cnt, o_stall_cnt, model_fetch, model_stall);
    end
    model_fetch = model_fetch + 32'(pop);
    model_stall = model_stall + 32'(o_valid && stall);
`endif
    @(posedge clk); #1;
    if (rv) m = mem_q.pop_front();
    if (fire) begin
      mreq_t n;
      n.addr = addr; n.epoch = epoch;
      mem_q.push_back(n);
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      next_req_pc = {tgt[31:2], 2'b00};
      halted = 0;
    end else begin
      if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (rv && m.epoch == epoch) begin
        e.pc = m.addr; e.fault = err; e.instr = err ? NOP : mem_word(m.addr);
        exp_q.push_back(e);
        if (err) halted = 1;
      end
      if (fire) next_req_pc = next_req_pc + 32'd4;
    end
    since_reset++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_redirect = 0; i_stall = 0; i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_err = 0;
    repeat (2) @(posedge clk);
    #4;
    checks++;
    if ({o_imem_req, o_valid, o_access_fault} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 000", {o_imem_req, o_valid, o_access_fault});
    end
    checks++;
    if (o_imem_addr !== RV) begin
      fails++; $display("FAIL reset_addr: got %h expected %h", o_imem_addr, RV);
    end
    checks++;
    if ({o_instr, o_pc} !== 64'h0) begin
      fails++; $display("FAIL reset_data: got %h/%h expected 0", o_instr, o_pc);
    end
    mem_q.delete(); exp_q.delete(); epoch++;
    next_req_pc = RV; halted = 0; since_reset = 0; hold_prev = 0;
    model_fetch = '0; model_stall = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] addrs[$];
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      step(0, '0, 0, 100, 100);
      if (s_req && addrs.size() < 3) addrs.push_back(s_addr);
      if (c < 3) begin
        checks++;
        if (s_valid !== 1'b0) begin
          fails++; $display("FAIL first_valid_early: cycle %0d got %b expected 0", c, s_valid);
        end
      end else if (c == 3) begin
        checks++;
        if (s_valid !== 1'b1 || s_pc !== RV) begin
          fails++; $display("FAIL first_valid: got %b pc %h expected 1 pc %h", s_valid, s_pc, RV);
        end
      end
    end
    checks++;
    if (addrs.size() < 3) begin
      fails++; $display("FAIL req_order: got %0d requests expected 3", addrs.size());
    end else if (addrs[0] !== RV || addrs[1] !== RV + 4 || addrs[2] !== RV + 8) begin
      fails++; $display("FAIL req_order: got %h %h %h expected %h %h %h",
                        addrs[0], addrs[1], addrs[2], RV, RV + 4, RV + 8);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0, prev;
    int          seen;
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) step(0, '0, 0, 100, 100);
    pc0 = '0;
    for (int s = 0; s < 5; s++) begin
      step(0, '0, 1, 100, 100);
      if (s == 0) pc0 = s_pc;
    end
    checks++;
    if (s_valid !== 1'b1 || s_pc !== pc0 || s_req !== 1'b0) begin
      fails++; $display("FAIL stall_end: got valid %b pc %h req %b expected 1 %h 0",
                        s_valid, s_pc, s_req, pc0);
    end
    prev = pc0 - 32'd4;
    seen = 0;
    for (int i = 0; i < 20 && seen < 6; i++) begin
      step(0, '0, 0, 100, 100);
      if (s_valid) begin
        checks++;
        if (s_pc !== prev + 32'd4) begin
          fails++; $display("FAIL stall_seq: got %h expected %h", s_pc, prev + 32'd4);
        end
        prev = s_pc;
        seen++;
      end
    end
  endtask

  task automatic test_redirect_inflight();
    int          reqs;
    logic [31:0] first_req, first_pc;
    bit          got_req, got_pc;
    step(1, 32'h500, 0, 100, 100);
    repeat (3) step(0, '0, 0, 0, 100);
    reqs = 0;
    repeat (3) begin
      step(0, '0, 0, 100, 0);
      reqs += int'(s_req);
    end
    checks++;
    if (reqs != 2) begin
      fails++; $display("FAIL inflight_reqs: got %0d expected 2", reqs);
    end
    step(1, 32'h2002, 0, 100, 0);
    got_req = 0; got_pc = 0; first_req = '0; first_pc = '0;
    for (int i = 0; i < 12; i++) begin
      step(0, '0, 0, 100, 100);
      if (s_req && !got_req) begin first_req = s_addr; got_req = 1; end
      if (s_valid && !got_pc) begin first_pc = s_pc; got_pc = 1; end
    end
    checks++;
    if (!got_req || first_req !== 32'h2000) begin
      fails++; $display("FAIL redirect_req: got %h expected 00002000", first_req);
    end
    checks++;
    if (!got_pc || first_pc !== 32'h2000) begin
      fails++; $display("FAIL redirect_pc: got %h expected 00002000", first_pc);
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    bit          found;
    bit          got_pc;
    logic [31:0] first_pc;
    step(1, 32'h300, 0, 100, 100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_q.size() != 0 && mem_q.size() != 0) found = 1;
      else step(0, '0, 0, 100, 100);
    end
    checks++;
    if (!found) begin
      fails++; $display("FAIL collide_setup: got no valid+rvalid cycle expected one within 20");
    end else begin
      step(1, 32'h400, 0, 100, 100);
      step(0, '0, 0, 100, 100);
      checks++;
      if (s_valid !== 1'b0) begin
        fails++; $display("FAIL collide_valid: got %b expected 0", s_valid);
      end
      got_pc = 0; first_pc = '0;
      for (int i = 0; i < 10 && !got_pc; i++) begin
        step(0, '0, 0, 100, 100);
        if (s_valid) begin first_pc = s_pc; got_pc = 1; end
      end
      checks++;
      if (first_pc !== 32'h400) begin
        fails++; $display("FAIL collide_pc: got %h expected 00000400", first_pc);
      end
    end
  endtask

  task automatic test_fault();
    bit          seen;
    int          reqs;
    logic [31:0] fpc, finstr;
    fault_en = 1; fault_addr = 32'h108;
    step(1, 32'h100, 0, 100, 100);
    seen = 0; fpc = '0; finstr = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(0, '0, 0, 100, 100);
      if (s_valid && s_fault) begin seen = 1; fpc = s_pc; finstr = s_instr; end
    end
    checks++;
    if (!seen || fpc !== 32'h108 || finstr !== NOP) begin
      fails++; $display("FAIL fault_entry: got seen %b pc %h instr %h expected 1 00000108 %h",
                        seen, fpc, finstr, NOP);
    end
    reqs = 0;
    repeat (8) begin
      step(0, '0, 0, 100, 100);
      reqs += int'(s_req);
    end
    checks++;
    if (reqs != 0) begin
      fails++; $display("FAIL halt_req: got %0d requests expected 0", reqs);
    end
    fault_en = 0;
    step(1, 32'h0, 0, 100, 100);
    step(0, '0, 0, 100, 100);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      fails++; $display("FAIL resume_req: got req %b addr %h expected 1 00000000", s_req, s_addr);
    end
  endtask

  task automatic test_random();
    logic        redir;
    logic [31:0] tgt;
    rand_fault = 1;
    for (int i = 0; i < 3000; i++) begin
      redir = ($urandom_range(0, 99) < 3);
      tgt   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(redir, tgt, ($urandom_range(0, 99) < 30), 75, 60);
    end
    rand_fault = 0;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    int   pops, stalls;
    logic st;
    apply_reset();
    pops = 0; stalls = 0;
    for (int i = 0; i < 60 && pops < 10; i++) begin
      st = (stalls < 3) && (exp_q.size() != 0);
      step(0, '0, st, 100, 100);
      if (s_valid && st)  stalls++;
      if (s_valid && !st) pops++;
    end
    step(0, '0, 0, 100, 100);
    checks++;
    if (s_fcnt !== 32'd10 || s_scnt !== 32'd3) begin
      fails++; $display("FAIL perf_final: got %0d/%0d expected 10/3", s_fcnt, s_scnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_redirect_inflight();
    test_redirect_rvalid_pop();
    test_fault();
    test_random();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
